// File: rtl/nanorisc_pkg.sv
// nanorisc_pkg: opcodes, FSM state encoding and datapath select codes shared
// by the NanoRisc control unit and its strobe decoder.
package nanorisc_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_SLT   = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_SEND0 = 4'h8;
    localparam logic [3:0] OP_SEND1 = 4'h9;
    localparam logic [3:0] OP_BEQ   = 4'hA;
    localparam logic [3:0] OP_J     = 4'hB;
    localparam logic [3:0] OP_JAL   = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEMACC, S_WB, S_HALT, S_ERROR
    } stateT;

    function automatic logic isAluOp(input logic [3:0] op);
        return op >= OP_ADD && op <= OP_SLT;
    endfunction

    // BEQ compares by subtraction, so it shares the SUB code
    function automatic logic [2:0] aluFor(input logic [3:0] op);
        return (op == OP_SUB || op == OP_BEQ) ? ALU_SUB :
               op == OP_AND ? ALU_AND :
               op == OP_OR  ? ALU_OR  :
               op == OP_SLT ? ALU_SLT : ALU_ADD;
    endfunction

    function automatic stateT decodeNext(input logic [3:0] op);
        return (isAluOp(op) || op == OP_BEQ || op == OP_J || op == OP_JAL) ? S_EXEC :
               (op == OP_LOAD || op == OP_STORE) ? S_MEMACC :
               (op == OP_SEND0 || op == OP_SEND1) ? S_WB :
               op == OP_NOP  ? S_FETCH :
               op == OP_HALT ? S_HALT : S_ERROR;
    endfunction

endpackage

// File: rtl/nanorisc_ctrl_decode.sv
// nanorisc_ctrl_decode: combinational map from FSM state and latched opcode to
// the memory, PC, ALU and register-bank strobes.
module nanorisc_ctrl_decode import nanorisc_pkg::*; (
    input  stateT      state,
    input  logic [3:0] opcode,
    input  logic       aluZero,
    input  logic       memReady,
    output logic       memReq,
    output logic       memWe,
    output logic       memAddrSel,
    output logic       irWrite,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic [2:0] aluOp,
    output logic       RegWrite,
    output logic       RegMemWrite,
    output logic       isSendType0,
    output logic       raWrite,
    output logic       busy,
    output logic       halted,
    output logic       error
);

    logic alu, exec, wb, jump, branch;

    always_comb begin
        alu         = isAluOp(opcode);
        exec        = state == S_EXEC;
        wb          = state == S_WB;
        jump        = exec && (opcode == OP_J || opcode == OP_JAL);
        branch      = exec && opcode == OP_BEQ && aluZero;
        memReq      = state == S_FETCH || state == S_MEMACC;
        memAddrSel  = state == S_MEMACC;
        memWe       = memAddrSel && opcode == OP_STORE;
        irWrite     = state == S_FETCH && memReady;
        pcWrite     = irWrite || jump || branch;
        pcSrc       = jump ? PC_JMP : branch ? PC_BR : PC_INC;
        aluOp       = (exec && (alu || opcode == OP_BEQ)) ? aluFor(opcode) : ALU_ADD;
        RegWrite    = wb && (alu || opcode == OP_SEND0 || opcode == OP_SEND1);
        RegMemWrite = wb && opcode == OP_LOAD;
        isSendType0 = wb && opcode == OP_SEND0;
        raWrite     = exec && opcode == OP_JAL;
        busy        = !(state == S_IDLE || state == S_HALT || state == S_ERROR);
        halted      = state == S_HALT;
        error       = state == S_ERROR;
    end

endmodule

// File: rtl/nanorisc_control_fsm.sv
// nanorisc_control_fsm: multi-cycle NanoRisc control unit; owns the state
// register, opcode latch and memory-wait timeout counter.
module nanorisc_control_fsm import nanorisc_pkg::*; #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       start,
    input  logic [7:0] instr,
    input  logic       memReady,
    input  logic       aluZero,
    output logic       memReq,
    output logic       memWe,
    output logic       memAddrSel,
    output logic       irWrite,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic [2:0] aluOp,
    output logic       RegWrite,
    output logic       RegMemWrite,
    output logic       isSendType0,
    output logic       raWrite,
    output logic       busy,
    output logic       halted,
    output logic       error
);

    stateT            state, nextState;
    logic [3:0]       opcode;
    logic [CNT_W-1:0] waitCnt;
    logic             memWait, timeout;
    logic             unusedOperand;

    // register operands are taken from the IR by the datapath
    assign unusedOperand = ^instr[3:0];
    assign memWait       = state == S_FETCH || state == S_MEMACC;
    assign timeout       = !memReady && waitCnt == CNT_W'(MEM_TIMEOUT - 1);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state   <= S_IDLE;
            opcode  <= '0;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= (memWait && !memReady) ? waitCnt + 1'b1 : '0;
            if (state == S_FETCH && memReady)
                opcode <= instr[7:4];
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:   nextState = start ? S_FETCH : S_IDLE;
            S_FETCH:  nextState = memReady ? S_DECODE : timeout ? S_ERROR : S_FETCH;
            S_DECODE: nextState = decodeNext(opcode);
            S_EXEC:   nextState = isAluOp(opcode) ? S_WB : S_FETCH;
            S_MEMACC: nextState = memReady ? (opcode == OP_LOAD ? S_WB : S_FETCH) :
                                  timeout ? S_ERROR : S_MEMACC;
            S_WB:     nextState = S_FETCH;
            S_HALT:   nextState = start ? S_FETCH : S_HALT;
            S_ERROR:  nextState = S_ERROR;
        endcase
    end

    nanorisc_ctrl_decode decode (
        .state(state), .opcode(opcode), .aluZero(aluZero), .memReady(memReady),
        .memReq(memReq), .memWe(memWe), .memAddrSel(memAddrSel), .irWrite(irWrite),
        .pcWrite(pcWrite), .pcSrc(pcSrc), .aluOp(aluOp), .RegWrite(RegWrite),
        .RegMemWrite(RegMemWrite), .isSendType0(isSendType0), .raWrite(raWrite),
        .busy(busy), .halted(halted), .error(error)
    );

endmodule

// File: tb/tb_nanorisc_control_fsm.sv
// tb_nanorisc_control_fsm: directed programs for the NanoRisc control unit;
// expected strobe vectors are queued by the stimulus and checked by a monitor.
module tb_nanorisc_control_fsm;

    logic       clock = 0;
    logic       resetN, start, memReady, aluZero;
    logic [7:0] instr;
    logic       memReq, memWe, memAddrSel, irWrite, pcWrite, RegWrite, RegMemWrite;
    logic       isSendType0, raWrite, busy, halted, error;
    logic [1:0] pcSrc;
    logic [2:0] aluOp;
    logic [16:0] outs;

    typedef struct { string name; logic [16:0] val; int cyc; } expT;
    expT sb[$];
    expT e;
    int  cyc = 0, nChecks = 0, nFails = 0;
    logic prevReq = 0, prevReady = 0, prevWe = 0, prevSel = 0, prevErr = 0, prevHalt = 0;

    nanorisc_control_fsm dut (
        .clock(clock), .resetN(resetN), .start(start), .instr(instr),
        .memReady(memReady), .aluZero(aluZero), .memReq(memReq), .memWe(memWe),
        .memAddrSel(memAddrSel), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
        .aluOp(aluOp), .RegWrite(RegWrite), .RegMemWrite(RegMemWrite),
        .isSendType0(isSendType0), .raWrite(raWrite), .busy(busy), .halted(halted),
        .error(error)
    );

    assign outs = {memReq, memWe, memAddrSel, irWrite, pcWrite, pcSrc, aluOp,
                   RegWrite, RegMemWrite, isSendType0, raWrite, busy, halted, error};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [16:0] v(input logic req, we, sel, ir, pcw, input logic [1:0] src,
                                      input logic [2:0] alu, input logic rw, rmw, st0, ra, bsy, hlt, err);
        return {req, we, sel, ir, pcw, src, alu, rw, rmw, st0, ra, bsy, hlt, err};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expectAt(input string name, input logic [16:0] val, input int at);
        sb.push_back('{name, val, at});
    endtask

    task automatic doFetch(input logic [7:0] ins, input int waits);
        memReady = 0;
        repeat (waits) tick();
        memReady = 1;
        instr = ins;
        expectAt($sformatf("fetch_%h", ins), v(1,0,0,1,1,2'd0,3'd0,0,0,0,0,1,0,0), cyc);
        tick();
        memReady = 0;
    endtask

    task automatic aluTest(input logic [7:0] ins, input int waits, input logic [2:0] alu);
        doFetch(ins, waits);
        expectAt("alu_decode", v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,1,0,0), cyc);
        expectAt("alu_exec",   v(0,0,0,0,0,2'd0,alu, 0,0,0,0,1,0,0), cyc + 1);
        expectAt("alu_wb",     v(0,0,0,0,0,2'd0,3'd0,1,0,0,0,1,0,0), cyc + 2);
        memReady = 1;
        repeat (2) tick();
        memReady = 0;
        tick();
    endtask

    task automatic memTest(input logic [7:0] ins, input int dwaits, input logic isStore);
        doFetch(ins, 0);
        expectAt("mem_decode", v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,1,0,0), cyc);
        start = 1;
        tick();
        start = 0;
        repeat (dwaits) tick();
        memReady = 1;
        expectAt("mem_done", v(1,isStore,1,0,0,2'd0,3'd0,0,0,0,0,1,0,0), cyc);
        if (!isStore) expectAt("load_wb", v(0,0,0,0,0,2'd0,3'd0,0,1,0,0,1,0,0), cyc + 1);
        tick();
        memReady = 0;
        if (!isStore) tick();
    endtask

    task automatic sendTest(input logic [7:0] ins, input logic st0);
        doFetch(ins, 0);
        expectAt("send_decode", v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,1,0,0), cyc);
        expectAt("send_wb",     v(0,0,0,0,0,2'd0,3'd0,1,0,st0,0,1,0,0), cyc + 1);
        repeat (2) tick();
    endtask

    task automatic execTest(input string name, input logic [7:0] ins, input logic zero,
                            input logic [16:0] execVal);
        doFetch(ins, 0);
        expectAt({name, "_decode"}, v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,1,0,0), cyc);
        expectAt({name, "_exec"}, execVal, cyc + 1);
        aluZero = zero;
        repeat (2) tick();
        aluZero = 0;
    endtask

    always @(negedge clock) begin
        if (resetN && ((memReq && memReady) || (busy && !memReq) || pcWrite || RegWrite ||
                       RegMemWrite || raWrite || (error && !prevErr) || (halted && !prevHalt))) begin
            nChecks++;
            if (sb.size() == 0) begin
                nFails++;
                $display("FAIL unexpected_event: got %h at cycle %0d, required no event", outs, cyc);
            end else begin
                e = sb.pop_front();
                if (outs !== e.val || cyc != e.cyc) begin
                    nFails++;
                    $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                             e.name, outs, cyc, e.val, e.cyc);
                end
            end
        end
        if (resetN && prevReq && !prevReady && !error) begin
            nChecks++;
            if ({memReq, memWe, memAddrSel} !== {1'b1, prevWe, prevSel}) begin
                nFails++;
                $display("FAIL handshake_hold: got %b at cycle %0d, required %b",
                         {memReq, memWe, memAddrSel}, cyc, {1'b1, prevWe, prevSel});
            end
        end
        if (resetN && (RegWrite || RegMemWrite || isSendType0)) begin
            nChecks++;
            if ((RegWrite && RegMemWrite) || (isSendType0 && !RegWrite)) begin
                nFails++;
                $display("FAIL strobe_exclusive: got rw=%b rmw=%b st0=%b at cycle %0d",
                         RegWrite, RegMemWrite, isSendType0, cyc);
            end
        end
        prevReq   = memReq;
        prevReady = memReady;
        prevWe    = memWe;
        prevSel   = memAddrSel;
        prevErr   = error;
        prevHalt  = halted;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        resetN = 0; start = 0; instr = 0; memReady = 0; aluZero = 0;
        repeat (2) tick();
        checkVal("reset_outputs", 32'(outs), 32'd0);
        resetN = 1;
        tick();
        checkVal("idle_outputs", 32'(outs), 32'd0);
        start = 1;
        tick();
        start = 0;
        aluTest(8'h1E, 2, 3'd0);
        aluTest(8'h23, 0, 3'd1);
        aluTest(8'h51, 1, 3'd4);
        memTest(8'h60, 3, 1'b0);
        memTest(8'h70, 1, 1'b1);
        sendTest(8'h80, 1'b1);
        sendTest(8'h90, 1'b0);
        execTest("beq_taken", 8'hA0, 1'b1, v(0,0,0,0,1,2'd1,3'd1,0,0,0,0,1,0,0));
        execTest("beq_not",   8'hA0, 1'b0, v(0,0,0,0,0,2'd0,3'd1,0,0,0,0,1,0,0));
        execTest("jump",      8'hB0, 1'b0, v(0,0,0,0,1,2'd2,3'd0,0,0,0,0,1,0,0));
        execTest("jal",       8'hC0, 1'b0, v(0,0,0,0,1,2'd2,3'd0,0,0,0,1,1,0,0));
        // ready arriving on the last permitted wait cycle still completes
        doFetch(8'h00, 14);
        expectAt("nop_decode", v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,1,0,0), cyc);
        tick();
        doFetch(8'hF0, 0);
        expectAt("halt_decode", v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,1,0,0), cyc);
        expectAt("halt_state",  v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,0,1,0), cyc + 1);
        repeat (3) tick();
        start = 1;
        tick();
        start = 0;
        expectAt("timeout_error", v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,0,0,1), cyc + 15);
        repeat (15) tick();
        repeat (2) begin
            start = 1;
            tick();
            start = 0;
            tick();
        end
        checkVal("error_sticky", 32'(outs), 32'(v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,0,0,1)));
        resetN = 0;
        #1;
        checkVal("error_cleared", 32'(outs), 32'd0);
        tick();
        resetN = 1;
        start = 1;
        tick();
        start = 0;
        doFetch(8'hD0, 0);
        expectAt("illegal_decode", v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,1,0,0), cyc);
        expectAt("illegal_error",  v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,0,0,1), cyc + 1);
        repeat (2) tick();
        resetN = 0;
        tick();
        resetN = 1;
        start = 1;
        tick();
        start = 0;
        doFetch(8'h60, 0);
        expectAt("abort_decode", v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,1,0,0), cyc);
        repeat (2) tick();
        checkVal("abort_memacc", 32'(outs), 32'(v(1,0,1,0,0,2'd0,3'd0,0,0,0,0,1,0,0)));
        #2;
        resetN = 0;
        #1;
        checkVal("abort_reset", 32'(outs), 32'd0);
        tick();
        resetN = 1;
        tick();
        checkVal("abort_idle", 32'(outs), 32'd0);
        start = 1;
        tick();
        start = 0;
        doFetch(8'h00, 0);
        expectAt("restart_decode", v(0,0,0,0,0,2'd0,3'd0,0,0,0,0,1,0,0), cyc);
        repeat (3) tick();
        checkVal("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
